// File: rtl/div_rr_scheduler.sv
// div_rr_scheduler: round-robin arbiter sharing one Start/Busy divider among NREQ requesters.
// Divide-by-zero is answered locally; a divider that never finishes is aborted after TIMEOUT cycles.
module div_rr_scheduler #(
   parameter int NREQ    = 4,
   parameter int W       = 8,
   parameter int TIMEOUT = 63
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic [NREQ-1:0]   done,
   output logic [W-1:0]      res_q,
   output logic [W-1:0]      res_r,
   output logic              res_err,
   output logic              sched_busy,
   output logic              div_start,
   output logic [W-1:0]      div_a,
   output logic [W-1:0]      div_b,
   input  logic              div_busy,
   input  logic [W-1:0]      div_q,
   input  logic [W-1:0]      div_r
);
   localparam int PW = $clog2(NREQ);
   localparam int CW = $clog2(TIMEOUT + 1);

   // Handshake: a requester holds req[i] high (with operands) until done[i] pulses for one cycle.
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [PW-1:0] ptr;
   logic [PW-1:0] winner;
   logic [W-1:0]  win_a;
   logic [W-1:0]  win_b;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_inc;
   logic          timeout;

   // Scan from farthest to nearest so the closest requester after ptr overrides the rest.
   always_comb begin
      winner = ptr;
      for (int k = NREQ; k >= 1; k--) begin
         if (req[(int'(ptr) + k) % NREQ]) winner = PW'((int'(ptr) + k) % NREQ);
      end
   end

   assign win_a   = req_a[winner*W +: W];
   assign win_b   = req_b[winner*W +: W];
   assign cnt_inc = cnt + 1'b1;
   assign timeout = (cnt_inc == CW'(TIMEOUT));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|req) state_nxt = (win_b == '0) ? DONE : ISSUE;
         ISSUE:   state_nxt = WAIT_HI;
         WAIT_HI: if (timeout) state_nxt = DONE;
                  else if (div_busy) state_nxt = WAIT_LO;
         WAIT_LO: if (timeout || !div_busy) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      done       = '0;
      div_start  = (state == ISSUE);
      sched_busy = (state != IDLE);
      if (state == DONE) done[ptr] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr     <= PW'(NREQ - 1);
         div_a   <= '0;
         div_b   <= '0;
         res_q   <= '0;
         res_r   <= '0;
         res_err <= 1'b0;
         cnt     <= '0;
      end else begin
         case (state)
            IDLE: if (|req) begin
               ptr   <= winner;
               div_a <= win_a;
               div_b <= win_b;
               if (win_b == '0) begin
                  res_q   <= '1;
                  res_r   <= win_a;
                  res_err <= 1'b1;
               end
            end
            ISSUE: cnt <= '0;
            WAIT_HI, WAIT_LO: begin
               cnt <= cnt_inc;
               // Abort wins over a Busy edge landing in the same cycle.
               if (timeout) begin
                  res_q   <= '0;
                  res_r   <= '0;
                  res_err <= 1'b1;
               end else if (state == WAIT_LO && !div_busy) begin
                  res_q   <= div_q;
                  res_r   <= div_r;
                  res_err <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
